// File: rtl/fft32_seq_ctrl.sv
// Start/hold controlled sequencer for the FFT32 datapath: two FFT16 passes
// (even, then odd samples) followed by a radix-2 combine stage.
module fft32_seq_ctrl #(
    parameter int STAGE_LEN    = 2,
    parameter int COMBINE_LEN  = 2,
    parameter int FFT16_STAGES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_hold,
    output logic       o_busy,
    output logic [1:0] w_mux_switcher,
    output logic       w_address_switcher,
    output logic       w_FFT16_cycle_rst,
    output logic [2:0] w_STAGES,
    output logic       w_FFT16_cycle_done_delay,
    output logic       o_FFT32_cycle_done
);

    localparam int CNT_W = 4 + $clog2(STAGE_LEN + 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(FFT16_STAGES * STAGE_LEN - 1);
    localparam logic [CNT_W-1:0] COMB_LAST = CNT_W'(COMBINE_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_RUN_A, S_CAP_A,
        S_LOAD_B, S_RUN_B, S_CAP_B, S_COMBINE, S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic       busy_reg, busy_next;
    logic [1:0] mux_reg, mux_next;
    logic       addr_reg, addr_next;
    logic       crst_reg, crst_next;
    logic [2:0] stages_reg, stages_next;
    logic       ddel_reg, ddel_next;
    logic       done_reg, done_next;

    // Thermometer of "counter has reached stage gi" for the upcoming cycle.
    logic [3:1] stage_ge;
    logic [2:0] stage_run;

    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_stage_ge
            assign stage_ge[gi] = (cnt_next >= CNT_W'(gi * STAGE_LEN));
        end
    endgenerate

    assign stage_run = {1'b0, stage_ge[2], (stage_ge[1] & ~stage_ge[2]) | stage_ge[3]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            mux_reg    <= 2'b00;
            addr_reg   <= 1'b0;
            crst_reg   <= 1'b0;
            stages_reg <= 3'd0;
            ddel_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            busy_reg   <= busy_next;
            mux_reg    <= mux_next;
            addr_reg   <= addr_next;
            crst_reg   <= crst_next;
            stages_reg <= stages_next;
            ddel_reg   <= ddel_next;
            done_reg   <= done_next;
        end
    end

    // Counter defaults to zero so every entry into a new state starts fresh.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            S_IDLE:   if (i_start) state_next = S_LOAD_A;
            S_LOAD_A: state_next = S_RUN_A;
            S_RUN_A: begin
                if (i_hold)                   cnt_next   = cnt_reg;
                else if (cnt_reg == RUN_LAST) state_next = S_CAP_A;
                else                          cnt_next   = cnt_reg + CNT_W'(1);
            end
            S_CAP_A:  state_next = S_LOAD_B;
            S_LOAD_B: state_next = S_RUN_B;
            S_RUN_B: begin
                if (i_hold)                   cnt_next   = cnt_reg;
                else if (cnt_reg == RUN_LAST) state_next = S_CAP_B;
                else                          cnt_next   = cnt_reg + CNT_W'(1);
            end
            S_CAP_B:  state_next = S_COMBINE;
            S_COMBINE: begin
                if (i_hold)                    cnt_next   = cnt_reg;
                else if (cnt_reg == COMB_LAST) state_next = S_DONE;
                else                           cnt_next   = cnt_reg + CNT_W'(1);
            end
            S_DONE:   state_next = i_start ? S_LOAD_A : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they line up with it once registered.
    always_comb begin
        busy_next   = (state_next != S_IDLE);
        mux_next    = 2'b00;
        addr_next   = 1'b0;
        crst_next   = 1'b0;
        stages_next = 3'd0;
        ddel_next   = 1'b0;
        done_next   = 1'b0;
        case (state_next)
            S_LOAD_A:  crst_next = 1'b1;
            S_RUN_A:   stages_next = stage_run;
            S_CAP_A:   ddel_next = 1'b1;
            S_LOAD_B: begin
                mux_next  = 2'b01;
                addr_next = 1'b1;
                crst_next = 1'b1;
            end
            S_RUN_B: begin
                mux_next    = 2'b01;
                addr_next   = 1'b1;
                stages_next = stage_run;
            end
            S_CAP_B: begin
                mux_next  = 2'b01;
                addr_next = 1'b1;
                ddel_next = 1'b1;
            end
            S_COMBINE: begin
                mux_next    = 2'b10;
                addr_next   = 1'b1;
                stages_next = 3'd4;
            end
            S_DONE: begin
                mux_next  = 2'b10;
                done_next = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_busy                   = busy_reg;
    assign w_mux_switcher           = mux_reg;
    assign w_address_switcher       = addr_reg;
    assign w_FFT16_cycle_rst        = crst_reg;
    assign w_STAGES                 = stages_reg;
    assign w_FFT16_cycle_done_delay = ddel_reg;
    assign o_FFT32_cycle_done       = done_reg;

endmodule

// File: tb/tb_fft32_seq_ctrl.sv
// Bench for fft32_seq_ctrl: two instances (default timing and the 1/1 minimum)
// compared cycle by cycle against a queue-of-cycles frame model.
module tb_fft32_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_rst   = 1'b1;
    logic i_start = 1'b0;
    logic i_hold  = 1'b0;

    logic       busy [2];
    logic [1:0] mux  [2];
    logic       addr [2];
    logic       crst [2];
    logic [2:0] stg  [2];
    logic       ddel [2];
    logic       done [2];

    fft32_seq_ctrl #(.STAGE_LEN(2), .COMBINE_LEN(2), .FFT16_STAGES(4)) dut0 (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_hold(i_hold),
        .o_busy(busy[0]), .w_mux_switcher(mux[0]), .w_address_switcher(addr[0]),
        .w_FFT16_cycle_rst(crst[0]), .w_STAGES(stg[0]),
        .w_FFT16_cycle_done_delay(ddel[0]), .o_FFT32_cycle_done(done[0])
    );

    fft32_seq_ctrl #(.STAGE_LEN(1), .COMBINE_LEN(1), .FFT16_STAGES(4)) dut1 (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_hold(i_hold),
        .o_busy(busy[1]), .w_mux_switcher(mux[1]), .w_address_switcher(addr[1]),
        .w_FFT16_cycle_rst(crst[1]), .w_STAGES(stg[1]),
        .w_FFT16_cycle_done_delay(ddel[1]), .o_FFT32_cycle_done(done[1])
    );

    typedef struct packed {
        logic [1:0] mux;
        logic       addr;
        logic       crst;
        logic [2:0] stg;
        logic       ddel;
        logic       done;
        logic       holdable;
    } ent_t;

    // Each queue holds the expected output of every remaining cycle of the frame.
    ent_t mq [2][$];
    int   sl_of [2] = '{2, 1};
    int   cl_of [2] = '{2, 1};
    int   start_cyc [2];
    int   held [2];
    int   crst_cnt [2];
    int   ddel_cnt [2];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    function automatic ent_t mk(input logic [1:0] m, input logic a, input logic c,
                                input logic [2:0] s, input logic dd, input logic dn,
                                input logic h);
        ent_t e;
        e.mux = m; e.addr = a; e.crst = c; e.stg = s;
        e.ddel = dd; e.done = dn; e.holdable = h;
        return e;
    endfunction

    task automatic push_frame(input int d);
        for (int p = 0; p < 2; p++) begin
            mq[d].push_back(mk(2'(p), 1'(p), 1'b1, 3'd0, 1'b0, 1'b0, 1'b0));
            for (int s = 0; s < 4; s++)
                for (int k = 0; k < sl_of[d]; k++)
                    mq[d].push_back(mk(2'(p), 1'(p), 1'b0, 3'(s), 1'b0, 1'b0, 1'b1));
            mq[d].push_back(mk(2'(p), 1'(p), 1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
        end
        for (int k = 0; k < cl_of[d]; k++)
            mq[d].push_back(mk(2'b10, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1));
        mq[d].push_back(mk(2'b10, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
        start_cyc[d] = cyc - 1;
        held[d]      = 0;
        crst_cnt[d]  = 0;
        ddel_cnt[d]  = 0;
    endtask

    task automatic model_step(input int d, input logic st, input logic hd, input logic rs);
        ent_t h;
        if (rs) begin
            mq[d].delete();
        end else if (mq[d].size() == 0) begin
            if (st) push_frame(d);
        end else begin
            h = mq[d][0];
            if (h.holdable && hd) begin
                held[d] = 1;
            end else begin
                void'(mq[d].pop_front());
                if (h.done && st) push_frame(d);
            end
        end
    endtask

    task automatic check_outputs();
        logic [9:0] exp_v, obs_v;
        ent_t h;
        int   lat;
        for (int d = 0; d < 2; d++) begin
            exp_v = '0;
            if (mq[d].size() != 0) begin
                h = mq[d][0];
                exp_v = {1'b1, h.mux, h.addr, h.crst, h.stg, h.ddel, h.done};
            end
            obs_v = {busy[d], mux[d], addr[d], crst[d], stg[d], ddel[d], done[d]};
            checks++;
            assert (obs_v === exp_v) else begin
                failures++;
                $error("FAIL trace dut%0d cyc=%0d observed=%b expected=%b (busy,mux,addr,rst,stg,ddel,done)",
                       d, cyc, obs_v, exp_v);
            end
            checks++;
            assert (mux[d] !== 2'b11) else begin
                failures++;
                $error("FAIL mux_never_11 dut%0d cyc=%0d observed=%b expected!=11", d, cyc, mux[d]);
            end
            if (crst[d] === 1'b1) crst_cnt[d]++;
            if (ddel[d] === 1'b1) ddel_cnt[d]++;
            if (done[d] === 1'b1 && mq[d].size() != 0) begin
                checks++;
                assert (crst_cnt[d] === 2 && ddel_cnt[d] === 2) else begin
                    failures++;
                    $error("FAIL pulse_count dut%0d cyc=%0d observed rst=%0d ddel=%0d expected 2/2",
                           d, cyc, crst_cnt[d], ddel_cnt[d]);
                end
                if (held[d] == 0) begin
                    lat = 8 * sl_of[d] + cl_of[d] + 5;
                    checks++;
                    assert ((cyc - start_cyc[d]) === lat) else begin
                        failures++;
                        $error("FAIL latency dut%0d cyc=%0d observed=%0d expected=%0d",
                               d, cyc, cyc - start_cyc[d], lat);
                    end
                end
            end
        end
    endtask

    task automatic step(input logic st, input logic hd, input logic rs);
        @(negedge clk);
        i_start = st;
        i_hold  = hd;
        i_rst   = rs;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) model_step(d, st, hd, rs);
        #1;
        check_outputs();
    endtask

    initial begin
        // Reset
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        // Single start pulse
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 30; k++) step(1'b0, 1'b0, 1'b0);
        // Start held: back-to-back frames
        for (int k = 0; k < 70; k++) step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 25; k++) step(1'b0, 1'b0, 1'b0);
        // Hold for 5 cycles during RUN_A
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 36; k++) step(1'b0, (k >= 5 && k <= 9), 1'b0);
        // Reset mid-frame, then a fresh frame
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 22; k++) step(1'b0, 1'b0, (k == 16));
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 30; k++) step(1'b0, 1'b0, 1'b0);
        // Start pulses while busy are ignored
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 30; k++) step((k == 5 || k == 12), 1'b0, 1'b0);
        // Randomized traffic
        for (int k = 0; k < 500; k++)
            step((($urandom % 4) == 0), (($urandom % 3) == 0), (($urandom % 97) == 0));
        for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
